// File: rtl/corelet_pkg.sv
// ---------------------------------------------------------------------------
// corelet_pkg
// Shared sizing constants for the corelet datapath and a helper that gives
// the pointer width used by the circular queues (address bits plus one
// wrap bit that separates "full" from "empty").
//   COL         : number of MAC array columns
//   PSUM_BW     : partial-sum width per column
//   OFIFO_DEPTH : entries per output column queue (power of two, >= 2)
// ---------------------------------------------------------------------------
package corelet_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    // Address bits for a depth-entry buffer plus one wrap bit.
    function automatic int ptr_width(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// ---------------------------------------------------------------------------
// ofifo_col
// One column queue of the output FIFO: a depth x psum_bw circular buffer.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointers only)
//   wr, din    : write strobe and data; ignored while full
//   rd         : pop the head entry; ignored while empty
//   full       : queue holds depth entries
//   empty      : queue holds no entries
//   head       : data at the read pointer (valid when !empty)
// ---------------------------------------------------------------------------
module ofifo_col
    import corelet_pkg::*;
#(
    parameter int depth   = OFIFO_DEPTH,
    parameter int psum_bw = PSUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] din,
    output logic               full,
    output logic               empty,
    output logic [psum_bw-1:0] head
);

    localparam int PW = ptr_width(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [psum_bw-1:0] mem [depth];

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is never reset; contents behind the read pointer are dead.
    always_ff @(posedge clk) begin
        if (!reset && wr && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ofifo.sv
// ---------------------------------------------------------------------------
// ofifo
// Output FIFO at the drain end of the corelet datapath. Every array column
// has its own queue written by its own valid strobe; a row is popped from all
// columns at once when each of them holds at least one entry.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in         : column data, column i at [(i+1)*psum_bw-1 : i*psum_bw]
//   wr         : per-column write strobes
//   rd         : pop one full row (accepted only while o_valid)
//   out        : registered row data, loaded one cycle after an accepted rd
//   o_full     : some column queue is full
//   o_ready    : every column queue has space
//   o_valid    : every column queue holds at least one entry
//   o_overflow : sticky dropped-write flag, present only when the macro
//                OFIFO_OVERFLOW_EN is defined
// ---------------------------------------------------------------------------
module ofifo
    import corelet_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid
`ifdef OFIFO_OVERFLOW_EN
   ,output logic                   o_overflow
`endif
);

    logic [col-1:0]         full_vec;
    logic [col-1:0]         empty_vec;
    logic [col*psum_bw-1:0] head_row;
    logic                   rd_accept;

    // Columns share the read strobe so a row always leaves as a unit.
    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .depth  (depth),
            .psum_bw(psum_bw)
        ) u_col (
            .clk  (clk),
            .reset(reset),
            .wr   (wr[i]),
            .rd   (rd_accept),
            .din  (in[i*psum_bw +: psum_bw]),
            .full (full_vec[i]),
            .empty(empty_vec[i]),
            .head (head_row[i*psum_bw +: psum_bw])
        );
    end

    assign o_full    = |full_vec;
    assign o_ready   = ~o_full;
    assign o_valid   = ~(|empty_vec);
    assign rd_accept = rd && o_valid;

    // Output row register: only an accepted read changes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (rd_accept) begin
            out <= head_row;
        end
    end

`ifdef OFIFO_OVERFLOW_EN
    // Sticky until reset: any strobe that hit a full column.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|(wr & full_vec)) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofifo.sv
// ---------------------------------------------------------------------------
// tb_ofifo
// Drives ofifo with directed and random traffic. A queue-based model decides
// which rows get popped; popped rows go to a scoreboard that an independent
// monitor drains whenever the DUT accepts a read.
// ---------------------------------------------------------------------------
module tb_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [COL*BW-1:0]   in;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [COL*BW-1:0]   out;
    logic                o_full;
    logic                o_ready;
    logic                o_valid;
`ifdef OFIFO_OVERFLOW_EN
    logic                o_overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: one plain queue per column, plus expected rows.
    logic [BW-1:0]       mq [COL][$];
    logic [COL*BW-1:0]   sb [$];
    logic                model_ovf = 1'b0;
    logic                mon_en    = 1'b0;

    ofifo dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .wr     (wr),
        .rd     (rd),
        .out    (out),
        .o_full (o_full),
        .o_ready(o_ready),
        .o_valid(o_valid)
`ifdef OFIFO_OVERFLOW_EN
       ,.o_overflow(o_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [COL*BW-1:0] got,
                         input logic [COL*BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Flags follow directly from model occupancies.
    task automatic checkOutput();
        logic exp_valid;
        logic exp_full;
        exp_valid = 1'b1;
        exp_full  = 1'b0;
        for (int i = 0; i < COL; i++) begin
            if (mq[i].size() == 0)     exp_valid = 1'b0;
            if (mq[i].size() == DEPTH) exp_full  = 1'b1;
        end
        check("o_valid", {127'd0, o_valid}, {127'd0, exp_valid});
        check("o_full",  {127'd0, o_full},  {127'd0, exp_full});
        check("o_ready", {127'd0, o_ready}, {127'd0, ~exp_full});
`ifdef OFIFO_OVERFLOW_EN
        check("o_overflow", {127'd0, o_overflow}, {127'd0, model_ovf});
`endif
    endtask

    // Model step using pre-edge occupancies.
    task automatic modelStep(input logic [COL-1:0] w, input logic r,
                             input logic [COL*BW-1:0] d, input logic rst);
        logic              vld;
        logic [COL-1:0]    fullc;
        logic [COL*BW-1:0] row;
        if (rst) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            sb.delete();
            model_ovf = 1'b0;
        end else begin
            vld = 1'b1;
            for (int i = 0; i < COL; i++) begin
                if (mq[i].size() == 0) vld = 1'b0;
                fullc[i] = (mq[i].size() == DEPTH);
                if (w[i] && fullc[i]) model_ovf = 1'b1;
            end
            if (r && vld) begin
                for (int i = 0; i < COL; i++) row[i*BW +: BW] = mq[i].pop_front();
                sb.push_back(row);
            end
            for (int i = 0; i < COL; i++) begin
                if (w[i] && !fullc[i]) mq[i].push_back(d[i*BW +: BW]);
            end
        end
    endtask

    // One clock cycle: check flags, drive inputs, advance the model.
    task automatic applyStimulus(input logic [COL-1:0] w, input logic r,
                                 input logic [COL*BW-1:0] d, input logic rst);
        @(negedge clk);
        if (mon_en) checkOutput();
        wr    = w;
        rd    = r;
        in    = d;
        reset = rst;
        @(posedge clk);
        modelStep(w, r, d, rst);
    endtask

    function automatic logic [COL*BW-1:0] randRow();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT takes a read and checks
    // that out holds otherwise.
    initial begin
        logic [COL*BW-1:0] exp_out;
        logic              fire;
        logic              rst_s;
        exp_out = '0;
        forever begin
            @(posedge clk);
            rst_s = reset;
            fire  = rd && o_valid && !reset;
            @(negedge clk);
            if (rst_s) begin
                exp_out = '0;
            end else if (fire) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read got %h expected no read at %0t", out, $time);
                end else begin
                    exp_out = sb.pop_front();
                end
            end
            if (mon_en) check("out", out, exp_out);
        end
    end

    initial begin
        logic [COL*BW-1:0] d;
        logic [COL*BW-1:0] stag_row;
        reset = 1'b1;
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        applyStimulus('0, 1'b0, '0, 1'b1);
        applyStimulus('0, 1'b0, '0, 1'b1);
        mon_en = 1'b1;

        // Idle after reset, including reads of an empty FIFO.
        applyStimulus('0, 1'b0, '0, 1'b0);
        #1;
        check("reset_out", out, '0);
        check("reset_ready", {127'd0, o_ready}, {127'd0, 1'b1});
        for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1, randRow(), 1'b0);

        // Staggered fill: column c writes once at cycle c.
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*BW +: BW] = 16'h0100 + 16'(c);
            applyStimulus(COL'(1) << c, 1'b0, d, 1'b0);
            #1;
            check("stagger_valid", {127'd0, o_valid}, {127'd0, (c == COL-1)});
        end
        applyStimulus('0, 1'b1, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        #1;
        for (int c = 0; c < COL; c++) stag_row[c*BW +: BW] = 16'h0100 + 16'(c);
        check("stagger_row", out, stag_row);
        check("stagger_valid_fall", {127'd0, o_valid}, '0);

        // Fill to full, one dropped write on column 3, drain plus one extra rd.
        for (int k = 0; k < DEPTH; k++) applyStimulus('1, 1'b0, randRow(), 1'b0);
        #1;
        check("full_flag", {127'd0, o_full}, {127'd0, 1'b1});
        applyStimulus(8'h08, 1'b0, {COL{16'hDEAD}}, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) applyStimulus('0, 1'b1, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);

        // One entry per column, then 100 cycles of simultaneous rd/wr.
        applyStimulus('1, 1'b0, randRow(), 1'b0);
        for (int k = 0; k < 100; k++) applyStimulus('1, 1'b1, randRow(), 1'b0);
        applyStimulus('0, 1'b1, '0, 1'b0);

        // Random traffic across many pointer wraps, some phases write-heavy.
        for (int k = 0; k < 1500; k++) begin
            logic [COL-1:0] w;
            w = COL'($urandom());
            if (k % 500 < 150) w = w | COL'($urandom());
            applyStimulus(w, ($urandom_range(0, 2) != 0), randRow(), 1'b0);
        end

        // Reset with ten rows queued, then restart clean.
        for (int k = 0; k < 10; k++) applyStimulus('1, 1'b0, randRow(), 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b1);
        applyStimulus('0, 1'b1, '0, 1'b0);
        #1;
        check("post_reset_out", out, '0);
        for (int k = 0; k < 200; k++)
            applyStimulus(COL'($urandom()) | COL'($urandom()), $urandom_range(0, 1) == 1,
                          randRow(), 1'b0);
        for (int k = 0; k < DEPTH + 2; k++) applyStimulus('0, 1'b1, '0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0);
        check("scoreboard_drained", 128'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output FIFO at the drain end of the corelet datapath; the opposite end of the L0/IFIFO input buffers.
- Accepts partial sums from the MAC array column by column. Each column writes independently when its own valid bit fires, because array outputs emerge staggered.
- Presents complete rows (all columns aligned) to the SFP/readout side through a single read handshake.
- Per-column write, whole-row read: the mirror of L0's whole-row write, per-row read.

Parameters:
- col, 8, number of array columns (independent column queues)
- psum_bw, 16, partial-sum width per column
- depth, 64, entries per column queue; power of two, >= 2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in  input  col*psum_bw  column data; column i occupies bits [(i+1)*psum_bw-1 : i*psum_bw]
- wr  input  col  per-column write strobe (array valid outputs)
- rd  input  1  pop one full row
- out  output  col*psum_bw  registered row data, same column packing as in
- o_full  output  1  any column queue full
- o_ready  output  1  all column queues have space (= ~o_full)
- o_valid  output  1  every column queue holds at least one entry

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on posedge clk; it dominates wr and rd in the same cycle.
- Reset values:
  - all write and read pointers 0
  - out = 0
  - o_full = 0
  - o_ready = 1
  - o_valid = 0
  - storage contents don't-care
- Each column queue is a circular buffer with rd_ptr and wr_ptr of $clog2(depth)+1 bits.
  - The extra MSB distinguishes full from empty.
  - empty_i: pointers are equal.
  - full_i: low bits are equal and MSBs differ.
  - Pointers wrap naturally modulo 2*depth.
- Write, column i:
  - If wr[i] && !full_i at the clock edge, store that column's slice of in at wr_ptr_i, then increment wr_ptr_i.
  - If wr[i] && full_i, the write is dropped and no pointer moves. Full is evaluated before any same-cycle read.
- Read:
  - Accepted iff rd && o_valid.
  - On acceptance, out is loaded with the head entry of every column on that edge and every rd_ptr_i increments. Data appears on out one cycle after rd is sampled.
  - rd with o_valid=0 is ignored; out holds its value and no pointer moves.
  - out holds its last value until the next accepted read.
- Simultaneous write and read on the same column:
  - Both take effect and the occupancy of that column is unchanged.
  - On an empty column, the written word is not readable that cycle; o_valid uses pre-edge state.
- Flag timing:
  - o_full = OR over full_i. o_ready = ~o_full.
  - o_valid = AND over ~empty_i.
  - All flags are combinational from registered pointers, so they change the cycle after the causing edge.
- Columns may drift. Rows are assembled purely by per-column order: the k-th word written to column i is paired with the k-th word of every other column.
- Reset mid-operation: all queued data is discarded and the reset values apply on the next cycle.

Optional Feature:
- Macro: OFIFO_OVERFLOW_EN.
- When defined:
  - Adds output port o_overflow (1 bit).
  - o_overflow is a sticky flag, set on the cycle after any wr[i] is asserted while full_i.
  - Cleared only by reset; reset value 0.
- When undefined: the port and logic are absent, and dropped writes are silent.

Decomposition:
- Shared package corelet_pkg holds:
  - default widths COL, PSUM_BW, OFIFO_DEPTH
  - a localparam function for pointer width
- Natural sub-module: ofifo_col, a single-column depth x psum_bw circular queue with wr, rd, full, empty and head data. It is instantiated col times via generate.
- Top-level ofifo holds:
  - row-level flag reduction
  - read acceptance
  - the out register
  - optional overflow flag

Test Plan:
- Reset then idle:
  - o_valid=0, o_full=0, o_ready=1, out=0.
  - rd asserted -> out stays 0 and no pointer change.
- Staggered fill:
  - Column i writes value 16'h0100+i starting at cycle i.
  - o_valid rises exactly one cycle after column 7's write.
  - rd -> next cycle out = {16'h0107,...,16'h0100}.
  - o_valid then falls.
- Fill to full:
  - 64 writes to all columns -> o_full=1, o_ready=0.
  - 65th write to column 3 is dropped.
  - 64 reads return values in order with no extra word.
  - With OFIFO_OVERFLOW_EN, o_overflow=1.
- Simultaneous read and write with each column holding 1 entry:
  - Every column stays at occupancy 1 for 100 cycles.
  - out stream matches the write stream delayed by one entry.
- Wrap-around: push and pop 200 rows through depth 64 -> all data correct, and flags correct across pointer wrap.
- Reset mid-stream with 10 rows queued:
  - Next cycle o_valid=0 and out=0.
  - Subsequent writes and reads start clean.
